// File: rtl/grid_pkg.sv
// Shared types and sizes for the grid-cell RAM arbiter slice.
// Holds cell/address widths, write-buffer depth and the owner tag.
package grid_pkg;

   localparam int GRID_CELLS  = 200;
   localparam int CELL_W      = 10;
   localparam int ADDR_W      = 8;
   localparam int WFIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VGA  = 2'd1,
      TAG_CPU  = 2'd2
   } owner_t;

   typedef enum logic {
      RR_WRITE = 1'b0,
      RR_READ  = 1'b1
   } rr_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [CELL_W-1:0] data;
   } wr_ent_t;

endpackage

// File: rtl/grid_wr_fifo.sv
// CPU write buffer: synchronous FIFO of {addr,data} entries.
// Ports: push/din in, pop in, head out, full out, count out.
import grid_pkg::*;

module grid_wr_fifo #(
   parameter int DEPTH = WFIFO_DEPTH
) (
   input  logic                       iVGA_CLK,
   input  logic                       iRST_n,
   input  logic                       push,
   input  wr_ent_t                    din,
   input  logic                       pop,
   output wr_ent_t                    head,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   wr_ent_t       store [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head = store[rd_ptr];
   assign full = (count == (AW+1)'(DEPTH));

   always_ff @(posedge iVGA_CLK) begin
      if (push) store[wr_ptr] <= din;
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // simultaneous push and pop leaves occupancy unchanged
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/grid_mem_arbiter.sv
// Shares the single-port grid RAM between VGA fetch and CPU access.
// VGA read first; CPU writes buffered and drained; CPU reads after drain.
import grid_pkg::*;

module grid_mem_arbiter (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic              vblank,
   input  logic              hold_vblank,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_rvalid,
   output logic [CELL_W-1:0] vga_rdata,
   input  logic              cpu_wr_valid,
   output logic              cpu_wr_ready,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [CELL_W-1:0] cpu_wr_data,
   input  logic              cpu_rd_valid,
   output logic              cpu_rd_ready,
   input  logic [ADDR_W-1:0] cpu_rd_addr,
   output logic              cpu_rd_rvalid,
   output logic [CELL_W-1:0] cpu_rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [CELL_W-1:0] mem_wdata,
   input  logic [CELL_W-1:0] mem_rdata
);

   localparam int CW = $clog2(WFIFO_DEPTH) + 1;

   wr_ent_t       wq_head;
   wr_ent_t       wq_din;
   logic          wq_full;
   logic [CW-1:0] wq_cnt;
   logic          wq_push;
   logic          wq_empty;

   logic   wr_cand;
   logic   rd_cand;
   logic   g_vga;
   logic   g_wr;
   logic   g_rd;
   rr_t    rr_q;
   rr_t    rr_d;
   owner_t tag_q;
   owner_t tag_d;

   logic [CELL_W-1:0] vga_hold_q;
   logic [CELL_W-1:0] cpu_hold_q;

   assign wq_empty     = (wq_cnt == '0);
   assign cpu_wr_ready = !wq_full;
   assign wq_push      = cpu_wr_valid & !wq_full;
   assign wq_din       = '{addr: cpu_wr_addr, data: cpu_wr_data};

   grid_wr_fifo #(
      .DEPTH (WFIFO_DEPTH)
   ) u_wq (
      .iVGA_CLK (iVGA_CLK),
      .iRST_n   (iRST_n),
      .push     (wq_push),
      .din      (wq_din),
      .pop      (g_wr),
      .head     (wq_head),
      .full     (wq_full),
      .count    (wq_cnt)
   );

   // reads wait for an empty buffer so they never overtake a write
   assign wr_cand = !wq_empty & (!hold_vblank | vblank);
   assign rd_cand = cpu_rd_valid & wq_empty;

   always_comb begin
      g_vga = 1'b0;
      g_wr  = 1'b0;
      g_rd  = 1'b0;
      rr_d  = rr_q;
      tag_d = TAG_NONE;
      if (vga_req) begin
         g_vga = 1'b1;
      end else if (wr_cand && rd_cand) begin
         if (rr_q == RR_WRITE) begin
            g_wr = 1'b1;
            rr_d = RR_READ;
         end else begin
            g_rd = 1'b1;
            rr_d = RR_WRITE;
         end
      end else if (wr_cand) begin
         g_wr = 1'b1;
      end else if (rd_cand) begin
         g_rd = 1'b1;
      end
      if (g_vga) tag_d = TAG_VGA;
      if (g_rd)  tag_d = TAG_CPU;
   end

   always_comb begin
      mem_en       = g_vga | g_wr | g_rd;
      mem_we       = g_wr;
      mem_addr     = '0;
      mem_wdata    = '0;
      cpu_rd_ready = g_rd;
      if (g_vga) mem_addr = vga_addr;
      if (g_rd)  mem_addr = cpu_rd_addr;
      if (g_wr) begin
         mem_addr  = wq_head.addr;
         mem_wdata = wq_head.data;
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         rr_q       <= RR_WRITE;
         tag_q      <= TAG_NONE;
         vga_hold_q <= '0;
         cpu_hold_q <= '0;
      end else begin
         rr_q  <= rr_d;
         tag_q <= tag_d;
         if (tag_q == TAG_VGA) vga_hold_q <= mem_rdata;
         if (tag_q == TAG_CPU) cpu_hold_q <= mem_rdata;
      end
   end

   // RAM data is live in the response cycle; held copy covers the rest
   assign vga_rvalid    = (tag_q == TAG_VGA);
   assign cpu_rd_rvalid = (tag_q == TAG_CPU);
   assign vga_rdata     = vga_rvalid    ? mem_rdata : vga_hold_q;
   assign cpu_rd_data   = cpu_rd_rvalid ? mem_rdata : cpu_hold_q;

endmodule
